// File: rtl/imem_fetch.sv
// Byte-addressable instruction memory with run-time loader and a prefetching fetch engine.
// Optional: define IMEM_BOUNDS_CHECK_EN to fault (instead of wrap) fetches past the array end.

package imem_fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned PF_DEPTH    = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD    = 32'h0000_003F
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           redir_valid,
    input  logic [31:0]                    redir_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [31:0]                    out_pc,
    output logic                           out_fault,
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] ld_addr,
    input  logic [7:0]                     ld_data
);

    localparam int unsigned AW    = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = $clog2(PF_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]        mem [DEPTH_BYTES];
    logic [31:0]       f_pc_q;
    logic              inflight_q;
    logic [31:0]       rd_word_q;
    logic [31:0]       rd_pc_q;
    logic              rd_fault_q;

    fetch_entry_t      buf_q [PF_DEPTH];
    fetch_entry_t      buf_d [PF_DEPTH];
    logic [PF_DEPTH-1:0] vld_q;
    logic [PF_DEPTH-1:0] vld_d;

    fetch_entry_t      push_entry_c;
    logic [CNT_W-1:0]  cnt_c;
    logic [31:0]       occ_c;
    logic              pop_c;
    logic              push_c;
    logic              issue_c;
    logic              redir_misaligned_c;
    logic              oob_c;
    logic [AW-1:0]     a0_c;
    logic [AW-1:0]     a1_c;
    logic [AW-1:0]     a2_c;
    logic [AW-1:0]     a3_c;

    assign redir_misaligned_c = (redir_pc[1:0] != 2'b00);
    assign pop_c  = vld_q[0] & out_ready;
    assign push_c = inflight_q & ~redir_valid;

    // Byte lanes of the read word, wrapping modulo the array size
    assign a0_c = f_pc_q[AW-1:0];
    assign a1_c = a0_c + AW'(1);
    assign a2_c = a0_c + AW'(2);
    assign a3_c = a0_c + AW'(3);

`ifdef IMEM_BOUNDS_CHECK_EN
    assign oob_c = (f_pc_q > 32'(DEPTH_BYTES - 4));
`else
    assign oob_c = 1'b0;
`endif

    // Occupancy seen by the issue logic: buffered + in flight - leaving this cycle
    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < int'(PF_DEPTH); i++) begin
            cnt_c = cnt_c + CNT_W'(vld_q[i]);
        end
        occ_c = 32'(cnt_c) + 32'(inflight_q) - 32'(pop_c);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; only a redirect moves between RUN and FAULT
    always_comb begin
        state_d = state_q;
        if (redir_valid) begin
            state_d = redir_misaligned_c ? ST_FAULT : ST_RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        issue_c = 1'b0;
        if ((state_q == ST_RUN) && !redir_valid && (occ_c < 32'(PF_DEPTH))) begin
            issue_c = 1'b1;
        end
    end

    // Loader write port; the fetch read below samples the pre-write contents
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Synchronous big-endian word read
    always_ff @(posedge clk) begin
        if (issue_c) begin
            rd_word_q <= {mem[a0_c], mem[a1_c], mem[a2_c], mem[a3_c]};
        end
    end

    always_comb begin
        push_entry_c.instr = rd_fault_q ? NOP_WORD : rd_word_q;
        push_entry_c.pc    = rd_pc_q;
        push_entry_c.fault = rd_fault_q;
    end

    // Shift-register FIFO: slot 0 is always the head, so outputs come straight from flops
    always_comb begin
        logic placed;
        placed = 1'b0;
        buf_d  = buf_q;
        vld_d  = vld_q;
        if (pop_c) begin
            for (int i = 0; i < int'(PF_DEPTH) - 1; i++) begin
                buf_d[i] = buf_q[i+1];
                vld_d[i] = vld_q[i+1];
            end
            vld_d[PF_DEPTH-1] = 1'b0;
        end
        if (push_c) begin
            for (int i = 0; i < int'(PF_DEPTH); i++) begin
                if (!placed && !vld_d[i]) begin
                    buf_d[i] = push_entry_c;
                    vld_d[i] = 1'b1;
                    placed   = 1'b1;
                end
            end
        end
        if (redir_valid) begin
            vld_d = '0;
        end
    end

    // Fetch PC, in-flight tracking and buffer state
    always_ff @(posedge clk) begin
        if (!reset) begin
            f_pc_q     <= RESET_PC;
            inflight_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_fault_q <= 1'b0;
            vld_q      <= '0;
            for (int i = 0; i < int'(PF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < int'(PF_DEPTH); i++) begin
                buf_q[i] <= buf_d[i];
            end
            if (redir_valid) begin
                // A misaligned target rides the read pipeline as a fault entry
                f_pc_q     <= redir_pc;
                inflight_q <= redir_misaligned_c;
                rd_pc_q    <= redir_pc;
                rd_fault_q <= redir_misaligned_c;
            end else begin
                inflight_q <= issue_c;
                if (issue_c) begin
                    f_pc_q     <= f_pc_q + 32'd4;
                    rd_pc_q    <= f_pc_q;
                    rd_fault_q <= oob_c;
                end
            end
        end
    end

    assign out_valid = vld_q[0];
    assign out_instr = buf_q[0].instr;
    assign out_pc    = buf_q[0].pc;
    assign out_fault = buf_q[0].fault;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed, table-driven bench for imem_fetch with a 16-byte array.

module tb_imem_fetch;

    localparam int unsigned DB  = 16;
    localparam logic [31:0] NOP = 32'h0000_003F;
    localparam logic [31:0] W0  = 32'h03FE_183F;
    localparam logic [31:0] W1  = 32'h0000_003F;
    localparam logic [31:0] W2  = 32'h8C01_0000;
    localparam logic [31:0] W3  = 32'hAC61_0000;
    localparam logic [31:0] W2N = 32'h1101_0000;

`ifdef IMEM_BOUNDS_CHECK_EN
    localparam logic [31:0] E16_I = NOP;
    localparam logic        E16_F = 1'b1;
`else
    localparam logic [31:0] E16_I = W0;
    localparam logic        E16_F = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data;

    imem_fetch #(
        .DEPTH_BYTES(DB),
        .PF_DEPTH   (2),
        .RESET_PC   (32'h0000_0000),
        .NOP_WORD   (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_fault  (out_fault),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        lwe;
        logic [3:0]  la;
        logic [7:0]  ld;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        ef;
        logic        chk_all;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rpc,
                                logic ev, logic [31:0] ei, logic [31:0] ep, logic ef);
        vec_t v;
        v.rs = 1'b1; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.lwe = 1'b0; v.la = 4'd0; v.ld = 8'd0;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ef = ef; v.chk_all = 1'b0;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prog [4];
        logic [31:0] w;
        vec_t        v;
        int          n;
        logic [31:0] exp_i [4];

        prog[0] = W0; prog[1] = W1; prog[2] = W2; prog[3] = W3;
        reset = 1'b0; redir_valid = 1'b0; redir_pc = '0; out_ready = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;

        // Load program while held in reset
        step();
        for (int i = 0; i < 16; i++) begin
            w       = prog[i / 4];
            ld_we   = 1'b1;
            ld_addr = 4'(i);
            ld_data = w[31 - 8 * (i % 4) -: 8];
            step();
        end
        ld_we = 1'b0;
        step();

        // Cycle-by-cycle table: check outputs, then drive inputs for the next edge
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));            // c0 reset state
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));            // c1 first issue edge done
        vecs.push_back(mk(1, 0, 0, 1, W0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, W1, 4, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 1, W2, 8, 0));  // c4..c8 stall
        vecs.push_back(mk(1, 0, 0, 1, W2, 8, 0));           // c9 resume
        vecs.push_back(mk(1, 0, 0, 1, W3, 12, 0));
        vecs.push_back(mk(0, 0, 0, 1, E16_I, 16, E16_F));   // c11 boundary fetch
        vecs.push_back(mk(0, 0, 0, 1, E16_I, 16, E16_F));   // c12 buffer full
        vecs.push_back(mk(1, 1, 12, 1, E16_I, 16, E16_F));  // c13 redirect to 12
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 6, 1, W3, 12, 0));          // c16 misaligned redirect
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, NOP, 6, 1));          // c18 fault entry
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));            // c20 redirect to 0
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, W0, 0, 0));           // c23 loader collision next edge
        vecs.push_back(mk(1, 0, 0, 1, W1, 4, 0));
        vecs.push_back(mk(1, 1, 8, 1, W2, 8, 0));           // c25 old byte, redirect to 8
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, W2N, 8, 0));          // c28 new byte
        vecs.push_back(mk(1, 0, 0, 1, W3, 12, 0));          // c29 reset pulse next edge
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));            // c30 reset values
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, W0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, W1, 4, 0));

        vecs[0].chk_all  = 1'b1;
        vecs[23].lwe     = 1'b1;
        vecs[23].la      = 4'd8;
        vecs[23].ld      = 8'h11;
        vecs[29].rs      = 1'b0;
        vecs[30].chk_all = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            chk($sformatf("c%0d_valid", i), 32'(out_valid), 32'(v.ev));
            if (v.ev || v.chk_all) begin
                chk($sformatf("c%0d_instr", i), out_instr, v.ei);
                chk($sformatf("c%0d_pc", i), out_pc, v.ep);
                chk($sformatf("c%0d_fault", i), 32'(out_fault), 32'(v.ef));
            end
            reset       = v.rs;
            out_ready   = v.rdy;
            redir_valid = v.rv;
            redir_pc    = v.rpc;
            ld_we       = v.lwe;
            ld_addr     = v.la;
            ld_data     = v.ld;
            step();
        end
        reset = 1'b1; redir_valid = 1'b0; ld_we = 1'b0; out_ready = 1'b1;

        // Redirect latency and back-to-back throughput over the reloaded program
        redir_valid = 1'b1;
        redir_pc    = 32'd0;
        step();
        redir_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        chk("redir_latency", 32'(n), 32'd2);
        exp_i[0] = W0; exp_i[1] = W1; exp_i[2] = W2N; exp_i[3] = W3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("burst%0d_instr", k), out_instr, exp_i[k]);
            chk($sformatf("burst%0d_pc", k), out_pc, 32'(4 * k));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
